// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC, memory read port, instruction buffer, redirect/halt handling.
// Build option FETCH_PREFETCH_EN deepens the instruction buffer from 1 to 2 entries.

// Generic shift-style FIFO with synchronous flush; head always sits in slot 0.
// Latency: push visible at out_dat the cycle after it is written into an empty FIFO.
// Backpressure: in_rdy drops when full unless the head is popped in the same cycle.
module fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_vld,
  output logic             in_rdy,
  input  logic [WIDTH-1:0] in_dat,
  output logic             out_vld,
  input  logic             out_rdy,
  output logic [WIDTH-1:0] out_dat
);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] slot     [DEPTH];
  logic [WIDTH-1:0] slot_ext [DEPTH+1];
  logic [WIDTH-1:0] slot_nxt [DEPTH];
  logic [CNT_W-1:0] cnt;
  logic             pop;
  logic             push;
  int               wr_pos;

  assign out_vld = (cnt != '0);
  assign out_dat = slot[0];
  assign pop     = out_vld & out_rdy;
  assign in_rdy  = (int'(cnt) < DEPTH) | pop;
  assign push    = in_vld & in_rdy;

  // Vacated slots shift in zero so an empty FIFO presents an all-zero head.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) slot_ext[i] = slot[i];
    slot_ext[DEPTH] = '0;
    wr_pos = pop ? int'(cnt) - 1 : int'(cnt);
    for (int i = 0; i < DEPTH; i++) begin
      slot_nxt[i] = pop ? slot_ext[i+1] : slot_ext[i];
      if (push && i == wr_pos) slot_nxt[i] = in_dat;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      cnt <= '0;
      for (int i = 0; i < DEPTH; i++) slot[i] <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) slot[i] <= slot_nxt[i];
      case ({push, pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end
endmodule

// Fetch stage: issues one read per cycle at PC and buffers {instr, pc} for decode.
// Latency: issue in cycle N gives instr_valid in N+1; redirect penalty is 2 cycles.
// Backpressure: issue stalls while the buffer is full and decode is not popping.
module fetch_unit #(
  parameter int                    ADDR_WIDTH = 12,
  parameter int                    DATA_WIDTH = 16,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic                  mem_read_enable,
  output logic                  mem_write_enable,
  input  logic [DATA_WIDTH-1:0] mem_data_out,
  input  logic                  mem_busy,
  input  logic                  redirect_valid,
  input  logic [ADDR_WIDTH-1:0] redirect_pc,
  input  logic                  halt_req,
  output logic                  instr_valid,
  output logic [DATA_WIDTH-1:0] instr,
  output logic [ADDR_WIDTH-1:0] instr_pc,
  input  logic                  instr_ready,
  output logic                  halted
);
`ifdef FETCH_PREFETCH_EN
  localparam int DEPTH = 2;
`else
  localparam int DEPTH = 1;
`endif

  typedef struct packed {
    logic [DATA_WIDTH-1:0] instr;
    logic [ADDR_WIDTH-1:0] pc;
  } fetch_entry_t;

  typedef enum logic {S_FETCH = 1'b0, S_HALT = 1'b1} state_t;

  state_t                state;
  state_t                state_nxt;
  logic                  in_fetch;
  logic [ADDR_WIDTH-1:0] pc;
  logic                  buf_rdy;
  logic                  issue;
  fetch_entry_t          push_dat;
  fetch_entry_t          head_dat;

  always_ff @(posedge clk) begin
    if (rst) state <= S_FETCH;
    else     state <= state_nxt;
  end

  // Redirect wins over a same-cycle halt request.
  always_comb begin
    state_nxt = state;
    case (state)
      S_FETCH: if (halt_req && !redirect_valid) state_nxt = S_HALT;
      S_HALT:  if (redirect_valid)              state_nxt = S_FETCH;
      default: state_nxt = S_FETCH;
    endcase
  end

  always_comb begin
    in_fetch = (state == S_FETCH);
    halted   = (state == S_HALT);
  end

  assign issue            = in_fetch & ~mem_busy & ~redirect_valid & ~rst & buf_rdy;
  assign mem_read_enable  = issue;
  assign mem_write_enable = 1'b0;
  assign mem_address      = pc;

  always_ff @(posedge clk) begin
    if (rst)                 pc <= RESET_PC;
    else if (redirect_valid) pc <= redirect_pc;
    else if (issue)          pc <= pc + 1'b1;
  end

  assign push_dat.instr = mem_data_out;
  assign push_dat.pc    = pc;

  fifo #(
    .WIDTH ($bits(fetch_entry_t)),
    .DEPTH (DEPTH)
  ) u_ibuf (
    .clk     (clk),
    .rst     (rst),
    .flush   (redirect_valid),
    .in_vld  (issue),
    .in_rdy  (buf_rdy),
    .in_dat  (push_dat),
    .out_vld (instr_valid),
    .out_rdy (instr_ready),
    .out_dat (head_dat)
  );

  assign instr    = head_dat.instr;
  assign instr_pc = head_dat.pc;
endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: memory word i holds 0x1000+i.
`timescale 1ns/1ps
module tb_fetch_unit;
  localparam int AW = 12;
  localparam int DW = 16;
`ifdef FETCH_PREFETCH_EN
  localparam int STALL_ISSUES = 2;
`else
  localparam int STALL_ISSUES = 1;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic [AW-1:0] mem_address;
  logic          mem_read_enable;
  logic          mem_write_enable;
  logic [DW-1:0] mem_data_out;
  logic          mem_busy;
  logic          redirect_valid;
  logic [AW-1:0] redirect_pc;
  logic          halt_req;
  logic          instr_valid;
  logic [DW-1:0] instr;
  logic [AW-1:0] instr_pc;
  logic          instr_ready;
  logic          halted;

  logic [DW-1:0] mem [1<<AW];
  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;
  assign mem_data_out = mem[mem_address];

  fetch_unit #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RESET_PC('0)) dut (
    .clk              (clk),
    .rst              (rst),
    .mem_address      (mem_address),
    .mem_read_enable  (mem_read_enable),
    .mem_write_enable (mem_write_enable),
    .mem_data_out     (mem_data_out),
    .mem_busy         (mem_busy),
    .redirect_valid   (redirect_valid),
    .redirect_pc      (redirect_pc),
    .halt_req         (halt_req),
    .instr_valid      (instr_valid),
    .instr            (instr),
    .instr_pc         (instr_pc),
    .instr_ready      (instr_ready),
    .halted           (halted)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic do_reset();
    rst            = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    halt_req       = 1'b0;
    mem_busy       = 1'b0;
    instr_ready    = 1'b1;
    repeat (2) tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    int issues;
    for (int i = 0; i < (1 << AW); i++) mem[i] = 16'(32'h1000 + i);

    // Reset values
    do_reset();
    settle();
    check("rst_valid",  32'(instr_valid),      32'd0);
    check("rst_rd_en",  32'(mem_read_enable),  32'd0);
    check("rst_wr_en",  32'(mem_write_enable), 32'd0);
    check("rst_addr",   32'(mem_address),      32'd0);
    check("rst_instr",  32'(instr),            32'd0);
    check("rst_ipc",    32'(instr_pc),         32'd0);
    check("rst_halted", 32'(halted),           32'd0);

    // Cycle 0 issues at RESET_PC, then one instruction per cycle
    rst = 1'b0;
    settle();
    check("c0_rd_en", 32'(mem_read_enable), 32'd1);
    check("c0_addr",  32'(mem_address),     32'd0);
    check("c0_valid", 32'(instr_valid),     32'd0);
    for (int k = 0; k < 3; k++) begin
      tick();
      settle();
      check("seq_valid", 32'(instr_valid), 32'd1);
      check("seq_instr", 32'(instr),       32'h1000 + 32'(k));
      check("seq_ipc",   32'(instr_pc),    32'(k));
    end

    // Decode stall for 4 cycles after the first instruction
    do_reset();
    instr_ready = 1'b0;
    rst = 1'b0;
    settle();
    issues = int'(mem_read_enable);
    for (int c = 1; c <= 4; c++) begin
      tick();
      settle();
      issues += int'(mem_read_enable);
      check("stall_valid", 32'(instr_valid), 32'd1);
      check("stall_instr", 32'(instr),       32'h1000);
      check("stall_ipc",   32'(instr_pc),    32'd0);
    end
    check("stall_rd_en",  32'(mem_read_enable), 32'd0);
    check("stall_issues", 32'(issues),          32'(STALL_ISSUES));
    tick();
    instr_ready = 1'b1;
    settle();
    for (int k = 0; k < 4; k++) begin
      check("rel_valid", 32'(instr_valid), 32'd1);
      check("rel_instr", 32'(instr),       32'h1000 + 32'(k));
      check("rel_ipc",   32'(instr_pc),    32'(k));
      tick();
      settle();
    end

    // Redirect while the buffer is full
    do_reset();
    instr_ready = 1'b0;
    rst = 1'b0;
    settle();
    repeat (3) tick();
    redirect_valid = 1'b1;
    redirect_pc    = 12'h080;
    settle();
    check("redir_full",  32'(instr_valid),     32'd1);
    check("redir_rd_en", 32'(mem_read_enable), 32'd0);
    tick();
    redirect_valid = 1'b0;
    instr_ready    = 1'b1;
    settle();
    check("redir1_valid", 32'(instr_valid),     32'd0);
    check("redir1_addr",  32'(mem_address),     32'h080);
    check("redir1_rd_en", 32'(mem_read_enable), 32'd1);
    tick();
    settle();
    check("redir2_valid", 32'(instr_valid), 32'd1);
    check("redir2_ipc",   32'(instr_pc),    32'h080);
    check("redir2_instr", 32'(instr),       32'h1080);

    // mem_busy for 3 cycles mid-stream
    tick();
    mem_busy = 1'b1;
    settle();
    check("busy_ipc", 32'(instr_pc), 32'h081);
    for (int c = 0; c < 3; c++) begin
      check("busy_rd_en", 32'(mem_read_enable), 32'd0);
      check("busy_addr",  32'(mem_address),     32'h082);
      if (c < 2) begin
        tick();
        settle();
      end
    end
    tick();
    mem_busy = 1'b0;
    settle();
    check("unbusy_rd_en", 32'(mem_read_enable), 32'd1);
    check("unbusy_addr",  32'(mem_address),     32'h082);
    check("unbusy_valid", 32'(instr_valid),     32'd0);
    tick();
    settle();
    check("unbusy_ipc0",   32'(instr_pc), 32'h082);
    check("unbusy_instr0", 32'(instr),    32'h1082);
    tick();
    settle();
    check("unbusy_ipc1",   32'(instr_pc), 32'h083);

    // PC wrap at the top of the address space
    tick();
    redirect_valid = 1'b1;
    redirect_pc    = 12'hFFF;
    settle();
    tick();
    redirect_valid = 1'b0;
    settle();
    check("wrap_addr0", 32'(mem_address),     32'hFFF);
    check("wrap_rd_en", 32'(mem_read_enable), 32'd1);
    tick();
    settle();
    check("wrap_ipc0",   32'(instr_pc),    32'hFFF);
    check("wrap_instr0", 32'(instr),       32'h1FFF);
    check("wrap_addr1",  32'(mem_address), 32'h000);
    tick();
    settle();
    check("wrap_ipc1",   32'(instr_pc), 32'h000);
    check("wrap_instr1", 32'(instr),    32'h1000);

    // Halt: same-cycle issue proceeds, then drain and stop
    tick();
    redirect_valid = 1'b1;
    redirect_pc    = 12'h020;
    settle();
    tick();
    redirect_valid = 1'b0;
    settle();
    tick();
    halt_req = 1'b1;
    settle();
    check("halt0_rd_en",  32'(mem_read_enable), 32'd1);
    check("halt0_addr",   32'(mem_address),     32'h021);
    check("halt0_halted", 32'(halted),          32'd0);
    tick();
    halt_req = 1'b0;
    settle();
    check("halt1_halted", 32'(halted),          32'd1);
    check("halt1_valid",  32'(instr_valid),     32'd1);
    check("halt1_ipc",    32'(instr_pc),        32'h021);
    check("halt1_rd_en",  32'(mem_read_enable), 32'd0);
    tick();
    halt_req = 1'b1;
    settle();
    check("halt2_valid", 32'(instr_valid),     32'd0);
    check("halt2_rd_en", 32'(mem_read_enable), 32'd0);
    tick();
    halt_req       = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc    = 12'h010;
    settle();
    check("halt3_halted", 32'(halted),          32'd1);
    check("halt3_rd_en",  32'(mem_read_enable), 32'd0);
    tick();
    redirect_valid = 1'b0;
    settle();
    check("resume_halted", 32'(halted),          32'd0);
    check("resume_addr",   32'(mem_address),     32'h010);
    check("resume_rd_en",  32'(mem_read_enable), 32'd1);
    tick();
    settle();
    check("resume_ipc",   32'(instr_pc), 32'h010);
    check("resume_instr", 32'(instr),    32'h1010);

    // Reset mid-stream
    tick();
    rst = 1'b1;
    settle();
    check("mrst0_rd_en", 32'(mem_read_enable), 32'd0);
    tick();
    settle();
    check("mrst_valid",  32'(instr_valid),     32'd0);
    check("mrst_instr",  32'(instr),           32'd0);
    check("mrst_ipc",    32'(instr_pc),        32'd0);
    check("mrst_addr",   32'(mem_address),     32'd0);
    check("mrst_halted", 32'(halted),          32'd0);
    check("mrst_rd_en",  32'(mem_read_enable), 32'd0);
    rst = 1'b0;
    settle();
    check("mrst_issue", 32'(mem_read_enable), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
